// File: rtl/alu.sv
// Registered integer ALU for the MIPS execute stage.
// The 4-bit control code selects one operation. The result and a zero flag
// are registered on the rising clock edge. The zero flag feeds the beq/bne
// branch decision. One operation is accepted every cycle with one edge of
// latency. There is no handshake and no enable.
module alu #(
    parameter int WIDTH = 32
) (
    output logic             zero,
    output logic [WIDTH-1:0] result,
    input  logic [3:0]       aluCtrl,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             clk,
    input  logic             reset
);

    // Only the low log2(WIDTH) bits of operand B give the shift distance.
    localparam int SHW = $clog2(WIDTH);

    // Operation encodings driven by the ALU control unit.
    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SLT  = 4'b0111,
        OP_SRA  = 4'b1000,
        OP_SLTU = 4'b1001,
        OP_NOR  = 4'b1100
    } alu_op_e;

    logic [SHW-1:0]          shamt;
    logic [WIDTH-1:0]        sum_val;
    logic [WIDTH-1:0]        diff_val;
    logic [WIDTH-1:0]        sll_val;
    logic [WIDTH-1:0]        srl_val;
    logic signed [WIDTH-1:0] sra_val;
    logic                    lt_signed;
    logic                    lt_unsigned;
    logic [WIDTH-1:0]        next_result;
    logic                    next_zero;

    // Shift distance, adder, subtractor, shifters and comparators.
    // They run in parallel so the select mux is the only serial stage.
    always_comb begin
        shamt       = input2[SHW-1:0];
        sum_val     = input1 + input2;
        diff_val    = input1 - input2;
        sll_val     = input1 << shamt;
        srl_val     = input1 >> shamt;
        sra_val     = $signed(input1) >>> shamt;
        lt_signed   = $signed(input1) < $signed(input2);
        lt_unsigned = input1 < input2;
    end

    // Select the operation result. Unassigned codes give 0, so zero reads 1.
    always_comb begin
        next_result = '0;
        case (alu_op_e'(aluCtrl))
            OP_AND:  next_result = input1 & input2;
            OP_OR:   next_result = input1 | input2;
            OP_ADD:  next_result = sum_val;
            OP_XOR:  next_result = input1 ^ input2;
            OP_SLL:  next_result = sll_val;
            OP_SRL:  next_result = srl_val;
            OP_SUB:  next_result = diff_val;
            OP_SLT:  next_result = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_SRA:  next_result = sra_val;
            OP_SLTU: next_result = {{(WIDTH-1){1'b0}}, lt_unsigned};
            OP_NOR:  next_result = ~(input1 | input2);
            default: next_result = '0;
        endcase
        next_zero = (next_result == '0);
    end

    // Output register. Reset takes priority and leaves a zero result with zero=1.
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= next_result;
            zero   <= next_zero;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed and random stimulus for the registered ALU, checked through an expected-result queue.
module tb_alu;

    localparam int WIDTH = 32;
    localparam int SHW   = 5;

    logic             clk;
    logic             reset;
    logic             zero;
    logic [WIDTH-1:0] result;
    logic [3:0]       aluCtrl;
    logic [WIDTH-1:0] input1;
    logic [WIDTH-1:0] input2;

    // Each entry holds {zero, result} expected after the next edge.
    logic [WIDTH:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    alu #(.WIDTH(WIDTH)) dut (
        .zero    (zero),
        .result  (result),
        .aluCtrl (aluCtrl),
        .input1  (input1),
        .input2  (input2),
        .clk     (clk),
        .reset   (reset)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent reference model, written from the operation table.
    function automatic logic [WIDTH-1:0] model(input logic [3:0] c,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        logic [SHW-1:0]   sh;
        ones = '1;
        sh   = b[SHW-1:0];
        r    = '0;
        case (c)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = a + b;
            4'b0011: r = a ^ b;
            4'b0100: r = a << sh;
            4'b0101: r = a >> sh;
            4'b0110: r = a + ~b + 1;
            4'b0111: r = (a[WIDTH-1] != b[WIDTH-1]) ? WIDTH'(a[WIDTH-1]) : WIDTH'(a < b);
            4'b1000: begin
                r = a >> sh;
                if (a[WIDTH-1]) r = r | ~(ones >> sh);
            end
            4'b1001: r = WIDTH'(a < b);
            4'b1100: r = ~a & ~b;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Pop the expected entry and compare it with the registered outputs.
    task automatic check_out(input string tag);
        logic [WIDTH:0] e;
        checks++;
        assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL %s queue_empty observed=%0d expected=1", tag, exp_q.size());
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            assert (result === e[WIDTH-1:0]) else begin
                errors++;
                $error("FAIL %s result observed=%h expected=%h", tag, result, e[WIDTH-1:0]);
            end
            checks++;
            assert (zero === e[WIDTH]) else begin
                errors++;
                $error("FAIL %s zero observed=%b expected=%b", tag, zero, e[WIDTH]);
            end
        end
    endtask

    // Driver task. Drive on the falling edge, queue the expected value,
    // then check 1 time unit after the rising edge.
    task automatic step(input string tag, input logic rst, input logic [3:0] c,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_res);
        @(negedge clk);
        reset   = rst;
        aluCtrl = c;
        input1  = a;
        input2  = b;
        exp_q.push_back({(exp_res == '0), exp_res});
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        logic [3:0]       rc;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        reset   = 1'b1;
        aluCtrl = 4'b0010;
        input1  = 32'd3;
        input2  = 32'd4;

        step("reset",       1'b1, 4'b0010, 32'd3,        32'd4,  32'h0);
        step("add",         1'b0, 4'b0010, 32'd5,        32'd50, 32'd55);
        step("srl",         1'b0, 4'b0101, 32'd8,        32'd1,  32'd4);
        step("srl_hi_b",    1'b0, 4'b0101, 32'd8,        32'd33, 32'd4);
        step("sub_eq",      1'b0, 4'b0110, 32'd7,        32'd7,  32'h0);
        step("sub_wrap",    1'b0, 4'b0110, 32'd0,        32'd1,  32'hFFFF_FFFF);
        step("slt",         1'b0, 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1);
        step("sltu",        1'b0, 4'b1001, 32'hFFFF_FFFF, 32'd1, 32'd0);
        step("slt_min",     1'b0, 4'b0111, 32'h8000_0000, 32'd0, 32'd1);
        step("sra",         1'b0, 4'b1000, 32'h8000_0000, 32'd4, 32'hF800_0000);
        step("nor",         1'b0, 4'b1100, 32'd0,        32'd0,  32'hFFFF_FFFF);
        step("undef",       1'b0, 4'b1111, 32'h1234_5678, 32'h9, 32'h0);
        step("and",         1'b0, 4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        step("or",          1'b0, 4'b0001, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F);
        step("xor",         1'b0, 4'b0011, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555);
        step("sll",         1'b0, 4'b0100, 32'h0000_0003, 32'h0000_0FFF, 32'h8000_0000);
        step("add_wrap",    1'b0, 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h0);
        step("reset_mid",   1'b1, 4'b0010, 32'd5,        32'd50, 32'h0);
        step("after_reset", 1'b0, 4'b0001, 32'h10,       32'h01, 32'h11);

        for (int i = 0; i < 40; i++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom();
            rb = $urandom();
            if (i % 8 == 0) rb = ra;
            step("random", 1'b0, rc, ra, rb, model(rc, ra, rb));
        end

        checks++;
        assert (exp_q.size() == 0) else begin
            errors++;
            $error("FAIL queue_drain observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
